// File: rtl/stepper_pkg.sv
// Shared types and coil patterns for the stepper dispense sequencer.
// Both step modes are kept here so that the phase generator can select one at build time.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DROP = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] COIL_OFF = 4'b0000;

    // Full step, one-hot: phase 0..3 = 0001, 0010, 0100, 1000
    localparam int          FULL_NPH = 4;
    localparam logic [15:0] FULL_PAT = {4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // Half step: phase 0..7 = 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001
    localparam int          HALF_NPH = 8;
    localparam logic [31:0] HALF_PAT = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

endpackage

// File: rtl/stepper_phase_gen.sv
// Per-channel coil phase generator.
// Build option STEPPER_HALF_STEP_EN selects the 8-phase half-step table;
// without it the 4-phase full-step one-hot table is used.
// Disabling the generator de-energises the coils and forgets the phase,
// so the next enabled tick always starts from phase 0 (0001).
module stepper_phase_gen
    import stepper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic       dir,
    output logic [3:0] coils
);

`ifdef STEPPER_HALF_STEP_EN
    localparam int              NPH = HALF_NPH;
    localparam logic [NPH*4-1:0] PAT = HALF_PAT;
`else
    localparam int              NPH = FULL_NPH;
    localparam logic [NPH*4-1:0] PAT = FULL_PAT;
`endif
    localparam logic [2:0] LAST = 3'(NPH - 1);

    logic [2:0] idx;
    logic [2:0] idx_nx;
    logic       on;

    // Next phase: restart at phase 0 from off, else step forward (dir=0) or backward (dir=1)
    always_comb begin
        idx_nx = 3'd0;
        if (on) begin
            if (dir) idx_nx = (idx == 3'd0) ? LAST : idx - 3'd1;
            else     idx_nx = (idx == LAST) ? 3'd0 : idx + 3'd1;
        end
    end

    // Phase state and registered coil drive; phase holds between ticks
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            idx   <= 3'd0;
            on    <= 1'b0;
            coils <= COIL_OFF;
        end else if (tick) begin
            idx   <= idx_nx;
            on    <= 1'b1;
            coils <= PAT[{idx_nx, 2'b00} +: 4];
        end
    end

endmodule

// File: rtl/stepper_dispense_seq.sv
// Multi-channel stepper dispense sequencer.
// Drops rounds[ch] back-and-forth strokes on each channel in turn, with an idle gap of
// GAP_STEPS step ticks between consecutive channels. All timing derives from a step tick
// produced by an internal prescaler that restarts on every accepted start.
// Build option STEPPER_HALF_STEP_EN (in stepper_phase_gen) selects half-step coil patterns.
module stepper_dispense_seq
    import stepper_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int CNT_W     = 10,
    parameter int STEP_DIV  = 524288,
    parameter int DEPTH     = 5,
    parameter int GAP_STEPS = 2
)(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     abort,
    input  logic [N_CH*CNT_W-1:0]                    rounds,
    output logic                                     busy,
    output logic                                     done,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_active,
    output logic [N_CH*4-1:0]                        coils
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PRE_W  = $clog2(STEP_DIV);
    localparam int STEP_W = $clog2(2 * DEPTH);
    localparam int GAP_W  = (GAP_STEPS > 1) ? $clog2(GAP_STEPS) : 1;

    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * DEPTH - 1);
    localparam logic [STEP_W-1:0] STEP_REV  = STEP_W'(DEPTH);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_STEPS - 1);

    state_t                 state;
    logic [CH_W-1:0]        ch;
    logic [PRE_W-1:0]       presc;
    logic [STEP_W-1:0]      step_cnt;
    logic [CNT_W-1:0]       rnd_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [N_CH*CNT_W-1:0]  rnd_lat;

    logic                   tick;
    logic                   dir;
    logic [CH_W-1:0]        nxt_ch;
    logic [CNT_W-1:0]       cur_rnd;
    logic [CNT_W-1:0]       nxt_rnd;
    state_t                 first_st;
    state_t                 gap_st;

    // Where a channel begins: drop if it has rounds, else straight to its gap, or finish if last
    function automatic state_t route(input logic has_rounds, input logic is_last);
        if (has_rounds) return DROP;
        if (is_last)    return DONE;
        return GAP;
    endfunction

    assign tick     = (presc == PRE_LAST);
    assign dir      = (step_cnt >= STEP_REV);
    assign nxt_ch   = (ch == LAST_CH) ? ch : ch + 1'b1;
    assign cur_rnd  = rnd_lat[ch * CNT_W +: CNT_W];
    assign nxt_rnd  = rnd_lat[nxt_ch * CNT_W +: CNT_W];
    assign first_st = route(rounds[CNT_W-1:0] != '0, N_CH == 1);
    assign gap_st   = route(nxt_rnd != '0, nxt_ch == LAST_CH);
    assign ch_active = ch;

    // Sequencer: prescaler, step/round/gap counters and channel walk
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ch       <= '0;
            presc    <= '0;
            step_cnt <= '0;
            rnd_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                presc    <= '0;
                step_cnt <= '0;
                rnd_cnt  <= '0;
                gap_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (start && !abort) begin
                            rnd_lat  <= rounds;
                            ch       <= '0;
                            step_cnt <= '0;
                            rnd_cnt  <= '0;
                            gap_cnt  <= '0;
                            state    <= first_st;
                            busy     <= (first_st != DONE);
                            done     <= (first_st == DONE);
                        end
                    end
                    DROP: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (step_cnt == STEP_LAST) begin
                                step_cnt <= '0;
                                if (rnd_cnt == cur_rnd - 1'b1) begin
                                    rnd_cnt <= '0;
                                    gap_cnt <= '0;
                                    if (ch == LAST_CH) begin
                                        state <= DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end else begin
                                        state <= GAP;
                                    end
                                end else begin
                                    rnd_cnt <= rnd_cnt + 1'b1;
                                end
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (gap_cnt == GAP_LAST) begin
                                gap_cnt <= '0;
                                ch      <= nxt_ch;
                                state   <= gap_st;
                                if (gap_st == DONE) begin
                                    busy <= 1'b0;
                                    done <= 1'b1;
                                end
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // One phase generator per channel; only the dropping channel is enabled, abort disables at once
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic en_ch;
        assign en_ch = (state == DROP) && (ch == CH_W'(i)) && !abort;
        stepper_phase_gen u_phase (
            .clk   (clk),
            .rst   (rst),
            .en    (en_ch),
            .tick  (tick),
            .dir   (dir),
            .coils (coils[i*4 +: 4])
        );
    end

endmodule
